// File: rtl/scalar_wb_pkg.sv
// Shared types for the scalar writeback arbiter: the request record written to
// the register file, the source tag used by arbitration, and a one-hot helper.
package scalar_wb_pkg;

    localparam int REG_SIZE = 32;
    localparam int REG_QTY  = 4;
    localparam int SEL_BITS = 2;

    typedef struct packed {
        logic [SEL_BITS-1:0] idx;
        logic [REG_SIZE-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SRC_MEM = 1'b0,
        SRC_ALU = 1'b1
    } wb_src_t;

    function automatic logic [REG_QTY-1:0] idx_onehot(input logic [SEL_BITS-1:0] idx);
        idx_onehot      = '0;
        idx_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests with a destination-register mask of
// every occupied entry, used to build the pending-write hazard mask.
module wb_fifo
    import scalar_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wb_req_t                  push_req,
    input  logic                     pop,
    output wb_req_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [REG_QTY-1:0]       dest_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    wb_req_t          mem_q [DEPTH];
    wb_req_t          mem_d [DEPTH];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_req;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; entries are only visible through count_q, which is.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        dest_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, ptr_t'(ptr_t'(i) - rd_ptr_q)} < count_q) begin
                dest_mask = dest_mask | idx_onehot(mem_q[i].idx);
            end
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Scalar writeback arbiter: queues ALU and load writes, grants one registered
// register-file write per cycle. Define SCALAR_WB_BYPASS_EN for 1-cycle bypass when idle.
module scalar_wb_arbiter
    import scalar_wb_pkg::*;
#(
    parameter int registerSize     = REG_SIZE,
    parameter int registerQuantity = REG_QTY,
    parameter int selectionBits    = SEL_BITS,
    parameter int FIFO_DEPTH       = 4,
    parameter int MAX_WAIT         = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        aluValid,
    output logic                        aluReady,
    input  logic [selectionBits-1:0]    aluReg,
    input  logic [registerSize-1:0]     aluData,
    input  logic                        memValid,
    output logic                        memReady,
    input  logic [selectionBits-1:0]    memReg,
    input  logic [registerSize-1:0]     memData,
    output logic                        regWrEn,
    output logic [selectionBits-1:0]    regToWrite,
    output logic [registerSize-1:0]     dataIn,
    output logic [registerQuantity-1:0] pendMask,
    output logic                        idle
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    wb_req_t                     alu_req, mem_req, alu_head, mem_head;
    logic                        alu_push, mem_push, alu_fifo_push, mem_fifo_push;
    logic                        alu_pop, mem_pop, alu_byp, mem_byp;
    logic                        alu_full, alu_empty, mem_full, mem_empty;
    logic [$clog2(FIFO_DEPTH):0] alu_count, mem_count;
    logic [REG_QTY-1:0]          alu_mask, mem_mask;
    logic                        grant;
    wb_src_t                     grant_src;

    logic                        run_q, run_d;
    logic [WAIT_W-1:0]           wait_q, wait_d;
    logic                        wr_en_q, wr_en_d;
    wb_req_t                     wr_req_q, wr_req_d;

    assign alu_req  = '{idx: aluReg, data: aluData};
    assign mem_req  = '{idx: memReg, data: memData};

    // Ready depends only on registered state, so a full FIFO stays closed while popping.
    assign aluReady = run_q && !alu_full;
    assign memReady = run_q && !mem_full;
    assign alu_push = aluValid && aluReady;
    assign mem_push = memValid && memReady;

`ifdef SCALAR_WB_BYPASS_EN
    logic both_empty;
    assign both_empty = alu_empty && mem_empty;
    assign mem_byp    = mem_push && both_empty;
    assign alu_byp    = alu_push && both_empty && !mem_push;
`else
    assign mem_byp    = 1'b0;
    assign alu_byp    = 1'b0;
`endif

    assign alu_fifo_push = alu_push && !alu_byp;
    assign mem_fifo_push = mem_push && !mem_byp;
    assign alu_pop       = grant && (grant_src == SRC_ALU);
    assign mem_pop       = grant && (grant_src == SRC_MEM);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (alu_fifo_push),
        .push_req  (alu_req),
        .pop       (alu_pop),
        .head      (alu_head),
        .full      (alu_full),
        .empty     (alu_empty),
        .count     (alu_count),
        .dest_mask (alu_mask)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (mem_fifo_push),
        .push_req  (mem_req),
        .pop       (mem_pop),
        .head      (mem_head),
        .full      (mem_full),
        .empty     (mem_empty),
        .count     (mem_count),
        .dest_mask (mem_mask)
    );

    // MEM wins by default; a starved ALU head takes the port once aluWait saturates.
    always_comb begin
        grant     = !alu_empty || !mem_empty;
        grant_src = SRC_MEM;
        wait_d    = wait_q;
        wr_en_d   = 1'b0;
        wr_req_d  = wr_req_q;
        run_d     = 1'b1;

        if (!alu_empty && (mem_empty || wait_q == WAIT_MAX)) begin
            grant_src = SRC_ALU;
        end

        if (alu_empty || alu_pop) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
        end

        // Bypass only fires with both FIFOs empty, so it never competes with a grant.
        if (alu_pop) begin
            wr_en_d  = 1'b1;
            wr_req_d = alu_head;
        end else if (mem_pop) begin
            wr_en_d  = 1'b1;
            wr_req_d = mem_head;
        end else if (mem_byp) begin
            wr_en_d  = 1'b1;
            wr_req_d = mem_req;
        end else if (alu_byp) begin
            wr_en_d  = 1'b1;
            wr_req_d = alu_req;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q    <= 1'b0;
            wait_q   <= '0;
            wr_en_q  <= 1'b0;
            wr_req_q <= '0;
        end else begin
            run_q    <= run_d;
            wait_q   <= wait_d;
            wr_en_q  <= wr_en_d;
            wr_req_q <= wr_req_d;
        end
    end

    assign regWrEn    = wr_en_q;
    assign regToWrite = wr_req_q.idx;
    assign dataIn     = wr_req_q.data;
    assign pendMask   = alu_mask | mem_mask | (wr_en_q ? idx_onehot(wr_req_q.idx) : '0);
    assign idle       = (alu_count == '0) && (mem_count == '0) && !wr_en_q;

endmodule
